fifo_nw1r_fwft: RTL and testbench

- Parametrised width-down-converting FIFO with first-word-fall-through (FWFT) output.
- Each write pushes one wide entry of 2^RATIO_LOG2 read words. Reads pop one narrow word at a time.
- Sub-word order is selectable. Adds level, almost-full and sticky error flags.
- Sits between wide producers (FFT butterfly/packer outputs) and narrow serial consumers.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/sdp_ram.sv | 30 +++
 rtl/fifo_nw1r_fwft.sv | 137 +++++++++++++
 tb/tb_fifo_nw1r_fwft.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Helpers shared by the width-down-converting FWFT FIFO and its bench model.
// Sub-word slot mapping: which din slice is popped as the j-th word of an entry.
package fifo_pkg;

   function automatic int unsigned ratio_words(input int unsigned ratio_log2);
      return 32'd1 << ratio_log2;
   endfunction

   // Slot s selects din[s*READ_WIDTH +: READ_WIDTH] for the j-th popped word.
   function automatic int unsigned subword_slot(input int unsigned j,
                                                input int unsigned n,
                                                input bit          upper_first);
      return upper_first ? (n - 32'd1 - j) : j;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
// The read register holds its value while rd_en is low, so it can act as a head register.
module sdp_ram #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_nw1r_fwft.sv
// Width-down-converting FIFO: one wide entry in per write, one narrow word out per pop,
// first-word-fall-through head held in the RAM read register.
module fifo_nw1r_fwft
   import fifo_pkg::*;
#(
   parameter int READ_WIDTH  = 8,
   parameter int RATIO_LOG2  = 1,
   parameter int DEPTH_LOG2  = 8,
   parameter int UPPER_FIRST = 1,
   parameter int AF_MARGIN   = 2
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [READ_WIDTH*(2**RATIO_LOG2)-1:0] din,
   input  logic                               wr_en,
   output logic                               full,
   output logic                               almost_full,
   output logic [READ_WIDTH-1:0]              dout,
   input  logic                               rd_en,
   output logic                               empty,
   output logic [DEPTH_LOG2:0]                level,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int N       = int'(ratio_words(RATIO_LOG2));
   localparam int ENTRY_W = READ_WIDTH * N;
   localparam int PTR_W   = DEPTH_LOG2;
   localparam int LVL_W   = DEPTH_LOG2 + 1;
   localparam int SEL_W   = (RATIO_LOG2 > 0) ? RATIO_LOG2 : 1;
   localparam int DEPTH   = 2**DEPTH_LOG2;

   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(DEPTH - AF_MARGIN);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N - 1);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              head_valid_q, head_valid_d;
   logic              full_q, full_d;
   logic              af_q, af_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              wr_acc, pop, pop_last, fetch;
   logic [LVL_W-1:0]  ram_entries;
   logic [ENTRY_W-1:0] head_entry;
   logic [SEL_W-1:0]  slot;
   logic [READ_WIDTH-1:0] words [2**SEL_W];

   // The RAM read register is the head entry; it is refilled when the head is absent or
   // its last word leaves, provided an entry written on an earlier edge is waiting.
   sdp_ram #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (CLK),
      .wr_en   (wr_acc && !RST),
      .wr_addr (wr_ptr_q),
      .wr_data (din),
      .rd_en   (fetch),
      .rd_addr (rd_ptr_q),
      .rd_data (head_entry)
   );

   always_comb begin
      wr_acc       = wr_en && !full_q;
      pop          = rd_en && head_valid_q;
      pop_last     = pop && (sel_q == SEL_LAST);
      ram_entries  = level_q - LVL_W'(head_valid_q);
      fetch        = (!head_valid_q || pop_last) && (ram_entries != '0);

      wr_ptr_d     = wr_ptr_q + PTR_W'(wr_acc);
      rd_ptr_d     = rd_ptr_q + PTR_W'(fetch);
      level_d      = level_q + LVL_W'(wr_acc) - LVL_W'(pop_last);
      head_valid_d = fetch ? 1'b1 : (pop_last ? 1'b0 : head_valid_q);

      sel_d = sel_q;
      if (pop) begin
         sel_d = pop_last ? '0 : sel_q + SEL_W'(1);
      end

      full_d       = (level_d == DEPTH_LVL);
      af_d         = (level_d >= AF_LVL);
      overflow_d   = overflow_q  || (wr_en && full_q);
      underflow_d  = underflow_q || (rd_en && !head_valid_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         sel_q        <= '0;
         head_valid_q <= 1'b0;
         full_q       <= 1'b0;
         af_q         <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         sel_q        <= sel_d;
         head_valid_q <= head_valid_d;
         full_q       <= full_d;
         af_q         <= af_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2**SEL_W; gi++) begin : g_word
         if (gi < N) begin : g_real
            assign words[gi] = head_entry[gi*READ_WIDTH +: READ_WIDTH];
         end else begin : g_pad
            assign words[gi] = '0;
         end
      end
   endgenerate

   assign slot = SEL_W'(subword_slot(32'(sel_q), 32'(N), UPPER_FIRST != 0));

   // dout is forced to zero while empty so reset shows a clean output without clearing the RAM.
   assign dout        = head_valid_q ? words[slot] : '0;
   assign empty       = !head_valid_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign level       = level_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_nw1r_fwft.sv
// Bench for fifo_nw1r_fwft: a default instance (2 words/entry, depth 256, upper first) driven
// through a word scoreboard, and a 4-words/entry, depth-4, lower-first instance for directed cases.
module tb_fifo_nw1r_fwft;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] a_din;
   logic        a_wr, a_rd, a_full, a_af, a_empty, a_ovf, a_unf;
   logic [7:0]  a_dout;
   logic [8:0]  a_level;

   logic [31:0] b_din;
   logic        b_wr, b_rd, b_full, b_af, b_empty, b_ovf, b_unf;
   logic [7:0]  b_dout;
   logic [2:0]  b_level;

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb [$];

   fifo_nw1r_fwft #(
      .READ_WIDTH(8), .RATIO_LOG2(1), .DEPTH_LOG2(8), .UPPER_FIRST(1), .AF_MARGIN(2)
   ) dut_a (
      .CLK(clk), .RST(rst), .din(a_din), .wr_en(a_wr), .full(a_full),
      .almost_full(a_af), .dout(a_dout), .rd_en(a_rd), .empty(a_empty),
      .level(a_level), .overflow(a_ovf), .underflow(a_unf)
   );

   fifo_nw1r_fwft #(
      .READ_WIDTH(8), .RATIO_LOG2(2), .DEPTH_LOG2(2), .UPPER_FIRST(0), .AF_MARGIN(2)
   ) dut_b (
      .CLK(clk), .RST(rst), .din(b_din), .wr_en(b_wr), .full(b_full),
      .almost_full(b_af), .dout(b_dout), .rd_en(b_rd), .empty(b_empty),
      .level(b_level), .overflow(b_ovf), .underflow(b_unf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
      b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
      step();
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   // One cycle on dut_a: accepted writes push their words, observed pops are compared.
   task automatic sb_cycle(input logic wr, input logic [15:0] d, input logic rd);
      logic [7:0] exp;
      a_wr = wr; a_din = d; a_rd = rd;
      if (wr && ((sb.size() + 1) / 2) < 256) begin
         sb.push_back(d[15:8]);
         sb.push_back(d[7:0]);
      end
      if (rd && !a_empty) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_extra_word: dut popped %02h, required no data", a_dout);
         end else begin
            exp = sb.pop_front();
            $display("pop dout=%02h expected=%02h", a_dout, exp);
            if (a_dout !== exp) begin
               failures++;
               $display("FAIL sb_dout: got %02h required %02h", a_dout, exp);
            end
         end
      end
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b required 1", a_empty); end
      checks++; if (a_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b required 0", a_full); end
      checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL reset_af: got %b required 0", a_af); end
      checks++; if (a_level !== 9'd0) begin failures++; $display("FAIL reset_level: got %0d required 0", a_level); end
      checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin failures++; $display("FAIL reset_flags: got ovf=%b unf=%b required 0 0", a_ovf, a_unf); end
      checks++; if (a_dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %02h required 00", a_dout); end
      checks++; if (b_empty !== 1'b1 || b_level !== 3'd0 || b_full !== 1'b0) begin failures++; $display("FAIL reset_b: got empty=%b level=%0d full=%b required 1 0 0", b_empty, b_level, b_full); end
   endtask

   task automatic test_latency();
      do_reset();
      sb_cycle(1'b1, 16'hA1B2, 1'b0);
      checks++; if (a_empty !== 1'b1 || a_level !== 9'd1) begin failures++; $display("FAIL lat_edge1: got empty=%b level=%0d required 1 1", a_empty, a_level); end
      sb_cycle(1'b0, 16'h0000, 1'b1);
      checks++; if (a_empty !== 1'b0 || a_dout !== 8'hA1) begin failures++; $display("FAIL lat_edge2: got empty=%b dout=%02h required 0 a1", a_empty, a_dout); end
      sb_cycle(1'b0, 16'h0000, 1'b1);
      checks++; if (a_dout !== 8'hB2 || a_level !== 9'd1) begin failures++; $display("FAIL lat_second: got dout=%02h level=%0d required b2 1", a_dout, a_level); end
      sb_cycle(1'b0, 16'h0000, 1'b1);
      checks++; if (a_empty !== 1'b1 || a_level !== 9'd0) begin failures++; $display("FAIL lat_drained: got empty=%b level=%0d required 1 0", a_empty, a_level); end
      checks++; if (a_unf !== 1'b1) begin failures++; $display("FAIL lat_underflow: got %b required 1", a_unf); end
      a_rd = 1'b0;
   endtask

   task automatic test_ratio4();
      logic [7:0] exp4 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      do_reset();
      b_din = 32'h11223344; b_wr = 1'b1;
      step();
      b_wr = 1'b0; b_rd = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b_empty !== 1'b0 || b_dout !== exp4[i] || b_level !== 3'd1) begin
            failures++;
            $display("FAIL r4_word%0d: got empty=%b dout=%02h level=%0d required 0 %02h 1", i, b_empty, b_dout, b_level, exp4[i]);
         end
         step();
      end
      b_rd = 1'b0;
      checks++; if (b_empty !== 1'b1 || b_level !== 3'd0) begin failures++; $display("FAIL r4_end: got empty=%b level=%0d required 1 0", b_empty, b_level); end
   endtask

   task automatic test_full_b();
      logic [31:0] ent [4];
      logic [31:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ent[i] = 32'hA0B0C0D0 + 32'(i) * 32'h01010101;
         b_din = ent[i]; b_wr = 1'b1;
         step();
         checks++;
         if (b_level !== 3'(i + 1) || b_af !== (i + 1 >= 2) || b_full !== (i + 1 == 4)) begin
            failures++;
            $display("FAIL fb_fill%0d: got level=%0d af=%b full=%b required %0d %b %b", i, b_level, b_af, b_full, i + 1, (i + 1 >= 2), (i + 1 == 4));
         end
      end
      b_din = 32'hDEADBEEF;
      step();
      b_wr = 1'b0;
      checks++; if (b_ovf !== 1'b1 || b_level !== 3'd4 || b_full !== 1'b1) begin failures++; $display("FAIL fb_overflow: got ovf=%b level=%0d full=%b required 1 4 1", b_ovf, b_level, b_full); end
      b_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = ent[i];
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (b_empty !== 1'b0 || b_dout !== e[j*8 +: 8]) begin
               failures++;
               $display("FAIL fb_drain%0d_%0d: got empty=%b dout=%02h required 0 %02h", i, j, b_empty, b_dout, e[j*8 +: 8]);
            end
            step();
         end
      end
      b_rd = 1'b0;
      checks++; if (b_empty !== 1'b1 || b_level !== 3'd0) begin failures++; $display("FAIL fb_end: got empty=%b level=%0d required 1 0", b_empty, b_level); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         sb_cycle(1'b1, 16'(i * 257) ^ 16'h5A00, 1'b0);
         if (i >= 250) begin
            checks++;
            if (a_af !== (i + 1 >= 254)) begin failures++; $display("FAIL fp_af%0d: got %b required %b", i, a_af, (i + 1 >= 254)); end
         end
      end
      checks++; if (a_full !== 1'b1 || a_level !== 9'd256) begin failures++; $display("FAIL fp_full: got full=%b level=%0d required 1 256", a_full, a_level); end
      sb_cycle(1'b0, 16'h0000, 1'b1);
      checks++; if (a_full !== 1'b1 || a_level !== 9'd256) begin failures++; $display("FAIL fp_partial: got full=%b level=%0d required 1 256", a_full, a_level); end
      sb_cycle(1'b1, 16'h7777, 1'b1);
      checks++; if (a_level !== 9'd255 || a_ovf !== 1'b1 || a_full !== 1'b0) begin failures++; $display("FAIL fp_refused: got level=%0d ovf=%b full=%b required 255 1 0", a_level, a_ovf, a_full); end
      sb_cycle(1'b1, 16'h8888, 1'b0);
      checks++; if (a_level !== 9'd256 || a_full !== 1'b1) begin failures++; $display("FAIL fp_accept: got level=%0d full=%b required 256 1", a_level, a_full); end
      for (int c = 0; c < 600 && sb.size() > 0; c++) begin
         sb_cycle(1'b0, 16'h0000, 1'b1);
      end
      a_rd = 1'b0;
      checks++; if (sb.size() != 0 || a_empty !== 1'b1 || a_level !== 9'd0) begin failures++; $display("FAIL fp_drain: got left=%0d empty=%b level=%0d required 0 1 0", sb.size(), a_empty, a_level); end
   endtask

   task automatic test_stream();
      bit seen;
      do_reset();
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (seen) begin
            checks++;
            if (a_empty && sb.size() > 0) begin failures++; $display("FAIL st_gap%0d: got empty=1 with %0d words pending required empty=0", c, sb.size()); end
         end
         if (!a_empty) seen = 1'b1;
         sb_cycle((c % 2 == 0) && (c < 160), 16'($urandom), !a_empty);
      end
      a_rd = 1'b0;
      checks++; if (sb.size() != 0 || a_empty !== 1'b1) begin failures++; $display("FAIL st_end: got left=%0d empty=%b required 0 1", sb.size(), a_empty); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      sb_cycle(1'b0, 16'h0000, 1'b1);
      checks++; if (a_unf !== 1'b1) begin failures++; $display("FAIL rm_unf_set: got %b required 1", a_unf); end
      for (int i = 0; i < 3; i++) sb_cycle(1'b1, 16'h1111 * 16'(i + 1), 1'b0);
      checks++; if (a_level !== 9'd3) begin failures++; $display("FAIL rm_level3: got %0d required 3", a_level); end
      rst = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_din = 16'hFFFF;
      step();
      rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
      sb.delete();
      checks++; if (a_empty !== 1'b1 || a_level !== 9'd0 || a_full !== 1'b0 || a_af !== 1'b0) begin failures++; $display("FAIL rm_state: got empty=%b level=%0d full=%b af=%b required 1 0 0 0", a_empty, a_level, a_full, a_af); end
      checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0 || a_dout !== 8'h00) begin failures++; $display("FAIL rm_flags: got ovf=%b unf=%b dout=%02h required 0 0 00", a_ovf, a_unf, a_dout); end
      step();
      checks++; if (a_empty !== 1'b1 || a_level !== 9'd0) begin failures++; $display("FAIL rm_ignored: got empty=%b level=%0d required 1 0", a_empty, a_level); end
      sb_cycle(1'b1, 16'hC3D4, 1'b0);
      sb_cycle(1'b0, 16'h0000, 1'b0);
      checks++; if (a_dout !== 8'hC3) begin failures++; $display("FAIL rm_head: got %02h required c3", a_dout); end
      sb_cycle(1'b0, 16'h0000, 1'b1);
      sb_cycle(1'b0, 16'h0000, 1'b1);
      a_rd = 1'b0;
      checks++; if (sb.size() != 0 || a_empty !== 1'b1) begin failures++; $display("FAIL rm_end: got left=%0d empty=%b required 0 1", sb.size(), a_empty); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
      b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
      test_reset();
      test_latency();
      test_ratio4();
      test_full_b();
      test_full_pop();
      test_stream();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
